// File: rtl/fetch_if.sv
// Fetch-side bus bundle: byte-wide instruction memory port, branch redirect
// from EX, and the instruction handshake towards decode.
//   master : fetch_seq (drives memory strobe/address and the decode side)
//   slave  : memory / EX / decode environment
interface fetch_if #(
    parameter int unsigned WIDTH = 32
);
    logic             mem_rd_en;
    logic [WIDTH-1:0] mem_addr;
    logic [7:0]       mem_rdata;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic             inst_valid;
    logic             inst_ready;
    logic [31:0]      instruction;
    logic [WIDTH-1:0] inst_pc;
    logic             busy;

    modport master (
        output mem_rd_en, mem_addr, inst_valid, instruction, inst_pc, busy,
        input  mem_rdata, branch_taken, branch_target, inst_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, inst_valid, instruction, inst_pc, busy,
        output mem_rdata, branch_taken, branch_target, inst_ready
    );
endinterface

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: reads a 32-bit word as four big-endian byte
// beats from a byte-wide memory with one cycle read latency, then presents
// it to decode with a valid/ready handshake. EX redirects abort the fetch.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fetch_if.master (mem_rd_en/mem_addr/mem_rdata, branch_taken/
//                branch_target, inst_valid/inst_ready/instruction/inst_pc, busy)
module fetch_seq #(
    parameter int unsigned     WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input logic     clk,
    input logic     rst_n,
    fetch_if.master bus
);

    localparam logic [1:0] S_START = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_VALID = 2'd3;

    localparam logic [1:0] LAST_BEAT = 2'd3;

    logic [1:0]       state, state_nx;
    logic [1:0]       beat, beat_nx;
    logic [WIDTH-1:0] pc, pc_nx;
    logic             cap_en;
    logic [1:0]       cap_idx;
    logic [WIDTH-1:0] target_aligned;

    assign target_aligned = bus.branch_target & ~WIDTH'(3);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_START;
            beat  <= 2'd0;
            pc    <= RESET_PC;
        end else begin
            state <= state_nx;
            beat  <= beat_nx;
            pc    <= pc_nx;
        end
    end

    // Next-state logic and byte-capture select
    always_comb begin
        state_nx = state;
        beat_nx  = beat;
        pc_nx    = pc;
        cap_en   = 1'b0;
        cap_idx  = beat - 2'd1;
        case (state)
            S_START: begin
                state_nx = S_FETCH;
                beat_nx  = 2'd0;
            end
            S_FETCH: begin
                // byte issued on the previous beat is on mem_rdata now
                cap_en = (beat != 2'd0);
                if (bus.branch_taken) begin
                    pc_nx   = target_aligned;
                    beat_nx = 2'd0;
                end else if (beat == LAST_BEAT) begin
                    state_nx = S_DRAIN;
                    beat_nx  = 2'd0;
                end else begin
                    beat_nx = beat + 2'd1;
                end
            end
            S_DRAIN: begin
                cap_en  = 1'b1;
                cap_idx = LAST_BEAT;
                if (bus.branch_taken) begin
                    state_nx = S_FETCH;
                    pc_nx    = target_aligned;
                    beat_nx  = 2'd0;
                end else begin
                    state_nx = S_VALID;
                end
            end
            S_VALID: begin
                // redirect wins over pc+4 whether or not decode accepts
                if (bus.branch_taken) begin
                    state_nx = S_FETCH;
                    pc_nx    = target_aligned;
                    beat_nx  = 2'd0;
                end else if (bus.inst_ready) begin
                    state_nx = S_FETCH;
                    pc_nx    = pc + WIDTH'(4);
                    beat_nx  = 2'd0;
                end
            end
            default: begin
                state_nx = S_START;
                beat_nx  = 2'd0;
            end
        endcase
    end

    // Registered outputs, computed from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_rd_en   <= 1'b0;
            bus.mem_addr    <= RESET_PC;
            bus.inst_valid  <= 1'b0;
            bus.busy        <= 1'b1;
            bus.instruction <= 32'd0;
            bus.inst_pc     <= RESET_PC;
        end else begin
            bus.mem_rd_en  <= (state_nx == S_FETCH);
            bus.mem_addr   <= pc_nx + WIDTH'(beat_nx);
            bus.inst_valid <= (state_nx == S_VALID);
            bus.busy       <= (state_nx != S_VALID);
            if (state == S_DRAIN) begin
                bus.inst_pc <= pc;
            end
            // big-endian assembly; stale bytes after a redirect land on
            // beat 0 where nothing is captured
            if (cap_en) begin
                case (cap_idx)
                    2'd0:    bus.instruction[31:24] <= bus.mem_rdata;
                    2'd1:    bus.instruction[23:16] <= bus.mem_rdata;
                    2'd2:    bus.instruction[15:8]  <= bus.mem_rdata;
                    default: bus.instruction[7:0]   <= bus.mem_rdata;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: reset, first fetch latency, back-pressure,
// redirect mid-fetch, redirect with handshake, address wrap, async reset.
module tb_fetch_seq;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    fetch_if #(.WIDTH(32)) bus ();

    fetch_seq #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: special word at 0, elsewhere byte = addr[7:0] ^ 0xA5
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h00;
            32'd2:   return 8'h50;
            32'd3:   return 8'h00;
            default: return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    // One-cycle read latency memory
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem_byte(bus.mem_addr);
        else               bus.mem_rdata <= 8'hEE;
    end

    task automatic test_reset;
        rst_n = 1'b0;
        bus.inst_ready = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = 32'h0;
        #12;
        tests_run++;
        if (bus.inst_valid !== 1'b0 || bus.mem_rd_en !== 1'b0 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ctl: valid=%b rd_en=%b busy=%b want 0 0 1",
                     bus.inst_valid, bus.mem_rd_en, bus.busy);
        end
        tests_run++;
        if (bus.instruction !== 32'h0 || bus.inst_pc !== 32'h0 || bus.mem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data: instr=%h pc=%h addr=%h want 0 0 0",
                     bus.instruction, bus.inst_pc, bus.mem_addr);
        end
    endtask

    task automatic test_first_fetch;
        @(negedge clk);
        rst_n = 1'b1;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'(i)) begin
                tests_failed++;
                $display("FAIL first_beat%0d: rd_en=%b addr=%h want 1 %h",
                         i, bus.mem_rd_en, bus.mem_addr, 32'(i));
            end
        end
        @(negedge clk);
        tests_run++;
        if (bus.mem_rd_en !== 1'b0 || bus.inst_valid !== 1'b0 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_drain: rd_en=%b valid=%b busy=%b want 0 0 1",
                     bus.mem_rd_en, bus.inst_valid, bus.busy);
        end
        @(negedge clk);
        tests_run++;
        if (bus.inst_valid !== 1'b1 || bus.instruction !== 32'h13005000 ||
            bus.inst_pc !== 32'h0 || bus.busy !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_valid: valid=%b instr=%h pc=%h busy=%b rd_en=%b want 1 13005000 0 0 0",
                     bus.inst_valid, bus.instruction, bus.inst_pc, bus.busy, bus.mem_rd_en);
        end
        @(negedge clk);
        tests_run++;
        if (bus.inst_valid !== 1'b0 || bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'h4) begin
            tests_failed++;
            $display("FAIL handshake_next: valid=%b rd_en=%b addr=%h want 0 1 4",
                     bus.inst_valid, bus.mem_rd_en, bus.mem_addr);
        end
        bus.inst_ready = 1'b0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.mem_addr !== 32'(4 + i)) begin
                tests_failed++;
                $display("FAIL second_beat%0d: addr=%h want %h", i, bus.mem_addr, 32'(4 + i));
            end
        end
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.inst_valid !== 1'b1 || bus.instruction !== 32'hA1A0A3A2 || bus.inst_pc !== 32'h4) begin
            tests_failed++;
            $display("FAIL second_valid: valid=%b instr=%h pc=%h want 1 a1a0a3a2 4",
                     bus.inst_valid, bus.instruction, bus.inst_pc);
        end
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.inst_valid !== 1'b1 || bus.instruction !== 32'hA1A0A3A2 ||
                bus.inst_pc !== 32'h4 || bus.mem_rd_en !== 1'b0 || bus.busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall%0d: valid=%b instr=%h pc=%h rd_en=%b busy=%b want 1 a1a0a3a2 4 0 0",
                         i, bus.inst_valid, bus.instruction, bus.inst_pc, bus.mem_rd_en, bus.busy);
            end
        end
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        tests_run++;
        if (bus.inst_valid !== 1'b0 || bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'h8) begin
            tests_failed++;
            $display("FAIL stall_release: valid=%b rd_en=%b addr=%h want 0 1 8",
                     bus.inst_valid, bus.mem_rd_en, bus.mem_addr);
        end
    endtask

    task automatic test_redirect_fetch;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.mem_addr !== 32'hA) begin
            tests_failed++;
            $display("FAIL pre_redirect_beat2: addr=%h want a", bus.mem_addr);
        end
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h40;
        @(negedge clk);
        bus.branch_taken = 1'b0;
        tests_run++;
        if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'h40) begin
            tests_failed++;
            $display("FAIL redirect_addr: rd_en=%b addr=%h want 1 40", bus.mem_rd_en, bus.mem_addr);
        end
        for (int i = 1; i < 4; i++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.inst_valid !== 1'b1 || bus.instruction !== 32'hE5E4E7E6 || bus.inst_pc !== 32'h40) begin
            tests_failed++;
            $display("FAIL redirect_word: valid=%b instr=%h pc=%h want 1 e5e4e7e6 40",
                     bus.inst_valid, bus.instruction, bus.inst_pc);
        end
    endtask

    task automatic test_branch_handshake;
        bus.inst_ready = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h103;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        bus.branch_taken = 1'b0;
        tests_run++;
        if (bus.inst_valid !== 1'b0 || bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'h100) begin
            tests_failed++;
            $display("FAIL br_hs_next: valid=%b rd_en=%b addr=%h want 0 1 100",
                     bus.inst_valid, bus.mem_rd_en, bus.mem_addr);
        end
        for (int i = 1; i < 4; i++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.inst_valid !== 1'b1 || bus.instruction !== 32'hA5A4A7A6 || bus.inst_pc !== 32'h100) begin
            tests_failed++;
            $display("FAIL br_hs_word: valid=%b instr=%h pc=%h want 1 a5a4a7a6 100",
                     bus.inst_valid, bus.instruction, bus.inst_pc);
        end
    endtask

    task automatic test_wrap;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.branch_taken = 1'b0;
        tests_run++;
        if (bus.inst_valid !== 1'b0 || bus.mem_addr !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("FAIL valid_redirect: valid=%b addr=%h want 0 fffffffc",
                     bus.inst_valid, bus.mem_addr);
        end
        for (int i = 1; i < 4; i++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.inst_valid !== 1'b1 || bus.instruction !== 32'h59585B5A || bus.inst_pc !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("FAIL wrap_word: valid=%b instr=%h pc=%h want 1 59585b5a fffffffc",
                     bus.inst_valid, bus.instruction, bus.inst_pc);
        end
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            tests_run++;
            if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'(i)) begin
                tests_failed++;
                $display("FAIL wrap_beat%0d: rd_en=%b addr=%h want 1 %h",
                         i, bus.mem_rd_en, bus.mem_addr, 32'(i));
            end
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        tests_run++;
        if (bus.mem_rd_en !== 1'b0 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_drain: rd_en=%b busy=%b want 0 1", bus.mem_rd_en, bus.busy);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.instruction !== 32'h0 || bus.inst_pc !== 32'h0 || bus.mem_addr !== 32'h0 ||
            bus.inst_valid !== 1'b0 || bus.mem_rd_en !== 1'b0 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_reset: instr=%h pc=%h addr=%h valid=%b rd_en=%b busy=%b want 0 0 0 0 0 1",
                     bus.instruction, bus.inst_pc, bus.mem_addr, bus.inst_valid, bus.mem_rd_en, bus.busy);
        end
    endtask

    task automatic test_start_branch;
        @(negedge clk);
        rst_n = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h80;
        @(negedge clk);
        bus.branch_taken = 1'b0;
        tests_run++;
        if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL start_branch_ignored: rd_en=%b addr=%h want 1 0",
                     bus.mem_rd_en, bus.mem_addr);
        end
        @(negedge clk);
        tests_run++;
        if (bus.mem_addr !== 32'h1) begin
            tests_failed++;
            $display("FAIL start_beat1: addr=%h want 1", bus.mem_addr);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect_fetch();
        test_branch_handshake();
        test_wrap();
        test_async_reset();
        test_start_branch();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
